pipeline_hazard_sequencer: RTL and testbench

// - Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB).
// - Arbitrates four hazard sources and drives per-stage register enables and bubble/flush controls:

---
 rtl/pipe_ctrl_pkg.sv | 12 +
 rtl/hazard_perf_counter.sv | 23 ++
 rtl/pipeline_hazard_sequencer.sv | 165 ++++++++++++++++
 tb/tb_pipeline_hazard_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline control block: FSM state codes and the
// architectural zero register.
package pipe_ctrl_pkg;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_MD_WAIT  = 2'd2;

    // x0 is hard-wired to zero, so it can never carry a load-use dependency.
    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/hazard_perf_counter.sv
// Saturating event counter with synchronous clear, used for hazard statistics.
module hazard_perf_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    // Count events, holding at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_sequencer.sv
// Stall/flush sequencer for the 5-stage pipeline. Multi-cycle waits (data
// memory, mul/div) are tracked by a small FSM; mispredict and load-use are
// decoded combinationally. Define HAZARD_PERF_CNT_EN to add saturating
// stall/flush/load-use performance counters.
module pipeline_hazard_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] if_id_rs1,
    input  logic [REG_AW-1:0] if_id_rs2,
    input  logic [REG_AW-1:0] id_ex_rd,
    input  logic              id_ex_mem_read,
    input  logic              ex_mispredict,
    input  logic              md_start,
    input  logic              md_done,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              id_ex_en,
    output logic              ex_mem_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_mem_bubble,
    output logic              mem_wb_bubble,
    output logic              mem_timeout,
    output logic [1:0]        fsm_state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count,
    output logic [CNT_W-1:0]  load_use_count
`endif
);

    localparam int unsigned WCW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(MEM_TIMEOUT);

    logic [1:0]     state_q, state_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           timeout_q, timeout_d;
    logic           memstall, load_use;
    logic           flush_evt, lu_evt;

    assign memstall = mem_req & ~mem_ready;
    assign load_use = id_ex_mem_read & (id_ex_rd != REG_AW'(REG_ZERO)) &
                      ((if_id_rs1 == id_ex_rd) | (if_id_rs2 == id_ex_rd));

    // Prioritised hazard decode: Mealy outputs and FSM next state.
    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_bubble = 1'b0;
        mem_wb_bubble = 1'b0;
        flush_evt     = 1'b0;
        lu_evt        = 1'b0;
        state_d       = state_q;
        if (!reset) begin
            if (memstall) begin
                // EX is frozen, so lower-priority hazards re-present afterwards.
                pc_en         = 1'b0;
                if_id_en      = 1'b0;
                id_ex_en      = 1'b0;
                ex_mem_en     = 1'b0;
                mem_wb_bubble = 1'b1;
                state_d       = ST_MEM_WAIT;
            end else if (state_q == ST_MD_WAIT) begin
                if (md_done) begin
                    state_d = ST_RUN;
                end else begin
                    pc_en         = 1'b0;
                    if_id_en      = 1'b0;
                    id_ex_en      = 1'b0;
                    ex_mem_bubble = 1'b1;
                end
            end else if ((state_q == ST_RUN) && md_start && !md_done) begin
                pc_en         = 1'b0;
                if_id_en      = 1'b0;
                id_ex_en      = 1'b0;
                ex_mem_bubble = 1'b1;
                state_d       = ST_MD_WAIT;
            end else begin
                // Leaving MEM_WAIT with a mul/div still pending moves straight to MD_WAIT.
                state_d = ((state_q == ST_MEM_WAIT) && md_start && !md_done) ? ST_MD_WAIT
                                                                             : ST_RUN;
                if (ex_mispredict) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    flush_evt   = 1'b1;
                end else if (load_use) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                    lu_evt      = 1'b1;
                end
            end
        end
    end

    // Wait counter runs only while memory stalls; the timeout flag is sticky.
    always_comb begin
        wait_cnt_d = '0;
        if (memstall) begin
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end
        timeout_d = timeout_q | (wait_cnt_d == WAIT_MAX);
    end

    // FSM state, wait counter and timeout flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign mem_timeout = timeout_q;
    assign fsm_state   = state_q;

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (~pc_en),
        .clr   (1'b0),
        .count (stall_cycles)
    );

    hazard_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_evt),
        .clr   (1'b0),
        .count (flush_count)
    );

    hazard_perf_counter #(.CNT_W(CNT_W)) u_lu_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (lu_evt),
        .clr   (1'b0),
        .count (load_use_count)
    );
`else
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
    logic unused_evt;
    assign unused_evt = flush_evt ^ lu_evt;
`endif

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Directed bench for pipeline_hazard_sequencer (MEM_TIMEOUT=4).
module tb_pipeline_hazard_sequencer;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned CNT_W  = 32;

    // Control vector: {pc,if_id,id_ex,ex_mem en, if_id_flush, id_ex_flush, ex_mem_bub, mem_wb_bub}
    localparam logic [7:0] C_DEF = 8'b1111_0000;
    localparam logic [7:0] C_LU  = 8'b0011_0100;
    localparam logic [7:0] C_MP  = 8'b1111_1100;
    localparam logic [7:0] C_MS  = 8'b0000_0001;
    localparam logic [7:0] C_MD  = 8'b0001_0010;

    logic              clk = 1'b0;
    logic              reset;
    logic [REG_AW-1:0] if_id_rs1, if_id_rs2, id_ex_rd;
    logic              id_ex_mem_read, ex_mispredict, md_start, md_done, mem_req, mem_ready;
    logic              pc_en, if_id_en, id_ex_en, ex_mem_en;
    logic              if_id_flush, id_ex_flush, ex_mem_bubble, mem_wb_bubble;
    logic              mem_timeout;
    logic [1:0]        fsm_state;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0]  stall_cycles, flush_count, load_use_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_sequencer #(
        .REG_AW      (REG_AW),
        .MEM_TIMEOUT (4),
        .CNT_W       (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .if_id_rs1      (if_id_rs1),
        .if_id_rs2      (if_id_rs2),
        .id_ex_rd       (id_ex_rd),
        .id_ex_mem_read (id_ex_mem_read),
        .ex_mispredict  (ex_mispredict),
        .md_start       (md_start),
        .md_done        (md_done),
        .mem_req        (mem_req),
        .mem_ready      (mem_ready),
        .pc_en          (pc_en),
        .if_id_en       (if_id_en),
        .id_ex_en       (id_ex_en),
        .ex_mem_en      (ex_mem_en),
        .if_id_flush    (if_id_flush),
        .id_ex_flush    (id_ex_flush),
        .ex_mem_bubble  (ex_mem_bubble),
        .mem_wb_bubble  (mem_wb_bubble),
        .mem_timeout    (mem_timeout),
        .fsm_state      (fsm_state)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count),
        .load_use_count (load_use_count)
`endif
    );

    logic [7:0] ctl;
    assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en,
                  if_id_flush, id_ex_flush, ex_mem_bubble, mem_wb_bubble};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic clear_inputs();
        if_id_rs1      = '0;
        if_id_rs2      = '0;
        id_ex_rd       = '0;
        id_ex_mem_read = 1'b0;
        ex_mispredict  = 1'b0;
        md_start       = 1'b0;
        md_done        = 1'b0;
        mem_req        = 1'b0;
        mem_ready      = 1'b0;
    endtask

    // Check the current cycle mid-period, then advance to just after the next edge.
    task automatic step(input string tag, input logic [7:0] exp_ctl, input logic [1:0] exp_st);
        @(negedge clk);
        check({tag, ".ctl"}, 32'(ctl), 32'(exp_ctl));
        check({tag, ".state"}, 32'(fsm_state), 32'(exp_st));
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        // Hazard inputs active during reset must not disturb the default outputs.
        reset     = 1'b1;
        mem_req   = 1'b1;
        ex_mispredict = 1'b1;
        #2;
        check("rst.ctl", 32'(ctl), 32'(C_DEF));
        check("rst.state", 32'(fsm_state), 32'd0);
        check("rst.timeout", 32'(mem_timeout), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_inputs();
        step("idle", C_DEF, 2'd0);

        // Load-use on rs2, one cycle, then the hazard is gone.
        id_ex_mem_read = 1'b1;
        id_ex_rd       = 5'd5;
        if_id_rs2      = 5'd5;
        step("lu", C_LU, 2'd0);
        clear_inputs();
        step("lu.after", C_DEF, 2'd0);

        // rd = x0 never stalls.
        id_ex_mem_read = 1'b1;
        id_ex_rd       = 5'd0;
        step("lu.x0", C_DEF, 2'd0);

        // Mispredict wins over a simultaneous load-use.
        id_ex_rd      = 5'd7;
        if_id_rs1     = 5'd7;
        ex_mispredict = 1'b1;
        step("mp", C_MP, 2'd0);
        clear_inputs();
        step("mp.after", C_DEF, 2'd0);

        // Memory wait: 3 stalled cycles, released on ready.
        mem_req = 1'b1;
        step("ms1", C_MS, 2'd0);
        step("ms2", C_MS, 2'd1);
        step("ms3", C_MS, 2'd1);
        mem_ready = 1'b1;
        step("ms.rdy", C_DEF, 2'd1);
        clear_inputs();
        step("ms.after", C_DEF, 2'd0);
        check("ms.timeout", 32'(mem_timeout), 32'd0);

        // Mul/div: started, done 4 cycles later.
        md_start = 1'b1;
        step("md0", C_MD, 2'd0);
        md_start = 1'b0;
        step("md1", C_MD, 2'd2);
        step("md2", C_MD, 2'd2);
        step("md3", C_MD, 2'd2);
        md_done = 1'b1;
        step("md.done", C_DEF, 2'd2);
        clear_inputs();
        step("md.after", C_DEF, 2'd0);

        // Start and done together: no stall.
        md_start = 1'b1;
        md_done  = 1'b1;
        step("md.fast", C_DEF, 2'd0);
        clear_inputs();
        step("md.fast.after", C_DEF, 2'd0);

`ifdef HAZARD_PERF_CNT_EN
        check("perf.stall", stall_cycles, 32'd8);
        check("perf.flush", flush_count, 32'd1);
        check("perf.lu", load_use_count, 32'd1);
`endif

        // Timeout: flag registered at the end of the 4th stall cycle, then sticky.
        mem_req = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check($sformatf("to.c%0d.ctl", k), 32'(ctl), 32'(C_MS));
            check($sformatf("to.c%0d.flag", k), 32'(mem_timeout), (k >= 5) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
        end
        check("to.hold", 32'(mem_timeout), 32'd1);

        // Reset mid-wait.
        reset = 1'b1;
        #2;
        check("to.rst.state", 32'(fsm_state), 32'd0);
        check("to.rst.flag", 32'(mem_timeout), 32'd0);
        check("to.rst.ctl", 32'(ctl), 32'(C_DEF));
`ifdef HAZARD_PERF_CNT_EN
        check("to.rst.perf", stall_cycles, 32'd0);
`endif
        reset = 1'b0;
        clear_inputs();
        step("post.rst", C_DEF, 2'd0);
        check("post.rst.flag", 32'(mem_timeout), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 100000", $time);
        $fatal(1);
    end

endmodule
